// File: rtl/lattice_render.sv
`default_nettype none
// ============================================================================
//  Module   : lattice_render
//  Purpose  : Maps LBM lattice distributions to scaled 24-bit video pixels.
//             Optional cell grid overlay enabled by defining LATTICE_GRID_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lattice_render #(
    parameter int          WIDTH      = 205,
    parameter int          HEIGHT     = 154,
    parameter int          BRAM_DEPTH = 31570,
    parameter int          LOG2_SCALE = 2,
    parameter logic [23:0] BORDER_RGB = 24'h202020
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [10:0]                        hcount_in,
    input  logic [9:0]                         vcount_in,
    input  logic                               active_in,
    input  logic                               new_frame_in,
    input  logic [1:0]                         mode_in,
    input  logic [8:0][7:0]                    bram_data_in,
    output logic [8:0][$clog2(BRAM_DEPTH)-1:0] addr_out,
    output logic [23:0]                        rgb_out,
    output logic                               active_out
);

    localparam int              AW       = $clog2(BRAM_DEPTH);
    localparam logic [10:0]     WIN_W    = 11'(WIDTH << LOG2_SCALE);
    localparam logic [9:0]      WIN_H    = 10'(HEIGHT << LOG2_SCALE);
    localparam logic [9:0]      LAST_V   = WIN_H - 10'd1;
    localparam logic [AW-1:0]   ROW_STEP = AW'(WIDTH);
    localparam logic [AW-1:0]   MAX_BASE = AW'((HEIGHT - 1) * WIDTH);
    localparam logic [1:0]      MODE_RHO = 2'd0;
    localparam logic [1:0]      MODE_UX  = 2'd1;
    localparam logic [1:0]      MODE_UY  = 2'd2;

    logic [AW-1:0]      row_base;
    logic [AW-1:0]      addr_q;
    logic [1:0]         frame_mode;
    logic               in_win;
    logic               row_step_en;
    logic [3:0]         act_pipe;
    logic [3:0]         win_pipe;
    logic [3:0][1:0]    mode_pipe;
    logic [9:0]         north, south, east, west;
    logic [11:0]        rho_c, rho_q;
    logic signed [10:0] ux_c, uy_c, ux_q, uy_q;
    logic [10:0]        spd_c, spd_q;
    logic [23:0]        rgb_c;

    function automatic logic [7:0] sat8(input logic [10:0] x);
        return (x > 11'd255) ? 8'hFF : x[7:0];
    endfunction

    function automatic logic [10:0] mag11(input logic signed [10:0] v);
        return v[10] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Positive component drawn red, negative drawn blue, at half magnitude.
    function automatic logic [23:0] polar(input logic signed [10:0] v);
        logic [10:0] half;
        half = {1'b0, mag11(v) >> 1};
        if (v > 11'sd0)
            return {sat8(half), 16'h0000};
        else if (v < 11'sd0)
            return {16'h0000, sat8(half)};
        else
            return 24'h000000;
    endfunction

    assign in_win      = (hcount_in < WIN_W) && (vcount_in < WIN_H);
    // Row base never advances past the last lattice row.
    assign row_step_en = (hcount_in == WIN_W) && (&vcount_in[LOG2_SCALE-1:0]) &&
                         (vcount_in != LAST_V) && (row_base != MAX_BASE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            row_base   <= '0;
            frame_mode <= '0;
        end else if (new_frame_in) begin
            row_base   <= '0;
            frame_mode <= mode_in;
        end else if (row_step_en) begin
            row_base   <= row_base + ROW_STEP;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q    <= '0;
            act_pipe  <= '0;
            win_pipe  <= '0;
            mode_pipe <= '0;
        end else begin
            if (in_win)
                addr_q <= row_base + AW'(hcount_in >> LOG2_SCALE);
            act_pipe  <= {act_pipe[2:0], active_in};
            win_pipe  <= {win_pipe[2:0], in_win};
            mode_pipe <= {mode_pipe[2:0], frame_mode};
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_lane
        assign addr_out[i] = addr_q;
    end

    // Lane order: 0 C, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW.
    always_comb begin
        rho_c = '0;
        for (int i = 0; i < 9; i++)
            rho_c = rho_c + 12'(bram_data_in[i]);
        north = 10'(bram_data_in[1]) + 10'(bram_data_in[2]) + 10'(bram_data_in[8]);
        south = 10'(bram_data_in[5]) + 10'(bram_data_in[4]) + 10'(bram_data_in[6]);
        east  = 10'(bram_data_in[2]) + 10'(bram_data_in[3]) + 10'(bram_data_in[4]);
        west  = 10'(bram_data_in[8]) + 10'(bram_data_in[7]) + 10'(bram_data_in[6]);
        ux_c  = $signed({1'b0, east}) - $signed({1'b0, west});
        uy_c  = $signed({1'b0, north}) - $signed({1'b0, south});
        spd_c = mag11(ux_c) + mag11(uy_c);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rho_q <= '0;
            ux_q  <= '0;
            uy_q  <= '0;
            spd_q <= '0;
        end else begin
            rho_q <= rho_c;
            ux_q  <= ux_c;
            uy_q  <= uy_c;
            spd_q <= spd_c;
        end
    end

`ifdef LATTICE_GRID_EN
    localparam int GRID_LSB = LOG2_SCALE + 3;
    logic       grid_c;
    logic [3:0] grid_pipe;

    assign grid_c = in_win && ((hcount_in[GRID_LSB-1:0] == '0) ||
                               (vcount_in[GRID_LSB-1:0] == '0));

    always_ff @(posedge clk_in) begin
        if (rst_in)
            grid_pipe <= '0;
        else
            grid_pipe <= {grid_pipe[2:0], grid_c};
    end
`endif

    always_comb begin
        case (mode_pipe[3])
            MODE_RHO: rgb_c = {3{sat8({2'b00, rho_q[11:3]})}};
            MODE_UX:  rgb_c = polar(ux_q);
            MODE_UY:  rgb_c = polar(uy_q);
            default:  rgb_c = {8'h00, sat8({1'b0, spd_q[10:1]}), 8'h00};
        endcase
`ifdef LATTICE_GRID_EN
        if (grid_pipe[3])
            rgb_c = 24'hFFFFFF;
`endif
        if (!win_pipe[3])
            rgb_c = BORDER_RGB;
        if (!act_pipe[3])
            rgb_c = 24'h000000;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rgb_out    <= '0;
            active_out <= 1'b0;
        end else begin
            rgb_out    <= rgb_c;
            active_out <= act_pipe[3];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lattice_render.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lattice_render
//  Purpose  : Self-checking bench for lattice_render with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lattice_render;

    localparam int WIDTH  = 205;
    localparam int HEIGHT = 154;
    localparam int DEPTH  = 31570;
    localparam int SC     = 4;

    typedef struct packed {
        logic [23:0] rgb;
        logic        act;
        logic        chk;
    } exp_t;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              active_in;
    logic              new_frame_in;
    logic [1:0]        mode_in;
    logic [8:0][7:0]   bram_data_in;
    logic [8:0][14:0]  addr_out;
    logic [23:0]       rgb_out;
    logic              active_out;

    logic [8:0][7:0]   mem [0:DEPTH-1];
    logic [8:0][7:0]   rd1, rd2;

    exp_t       q[$];
    logic [1:0] fm_model;
    bit         sb_valid;
    int         n_cmp = 0;
    int         n_bad = 0;

    lattice_render dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .active_in    (active_in),
        .new_frame_in (new_frame_in),
        .mode_in      (mode_in),
        .bram_data_in (bram_data_in),
        .addr_out     (addr_out),
        .rgb_out      (rgb_out),
        .active_out   (active_out)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle read latency BRAM port.
    always @(posedge clk_in) begin
        rd1 <= mem[addr_out[0]];
        rd2 <= rd1;
    end
    assign bram_data_in = rd2;

    function automatic logic [7:0] sat(input int x);
        return (x > 255) ? 8'hFF : 8'(x);
    endfunction

    function automatic logic [23:0] pol(input int x);
        if (x > 0) return {sat(x / 2), 16'h0000};
        if (x < 0) return {16'h0000, sat((-x) / 2)};
        return 24'h000000;
    endfunction

    function automatic logic [23:0] model_rgb(input int h, input int v, input bit act,
                                              input logic [1:0] m);
        int d[9];
        int rho, ux, uy, idx;
        if (!act) return 24'h000000;
        if (h >= WIDTH * SC || v >= HEIGHT * SC) return 24'h202020;
        idx = (v / SC) * WIDTH + h / SC;
        rho = 0;
        for (int i = 0; i < 9; i++) begin
            d[i] = int'(mem[idx][i]);
            rho += d[i];
        end
        ux = (d[2] + d[3] + d[4]) - (d[8] + d[7] + d[6]);
        uy = (d[1] + d[2] + d[8]) - (d[5] + d[4] + d[6]);
        case (m)
            2'd0:    return {3{sat(rho / 8)}};
            2'd1:    return pol(ux);
            2'd2:    return pol(uy);
            default: return {8'h00, sat(((ux < 0 ? -ux : ux) + (uy < 0 ? -uy : uy)) / 2), 8'h00};
        endcase
    endfunction

    // One clock of stimulus; returns the expectation now due at the outputs.
    task automatic drive(input int h, input int v, input bit act, input bit nf,
                         input bit rst, output exp_t f, output bit got);
        exp_t e;
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        active_in    = act;
        new_frame_in = nf;
        rst_in       = rst;
        e = '{rgb: model_rgb(h, v, act, fm_model), act: act, chk: sb_valid};
        if (!rst && nf) begin
            fm_model = mode_in;
            sb_valid = 1'b1;
        end
        @(posedge clk_in);
        #1;
        f   = '0;
        got = 1'b0;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) q.push_back('{rgb: 24'h0, act: 1'b0, chk: 1'b1});
            fm_model = 2'd0;
            sb_valid = 1'b0;
        end else begin
            q.push_back(e);
            if (q.size() >= 5) begin
                f   = q.pop_front();
                got = 1'b1;
            end
        end
    endtask

    task automatic fill_mem(input int kind);
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < 9; j++)
                mem[i][j] = (kind == 0) ? 8'h0A : 8'($urandom);
    endtask

    // Full frame: vblank line carrying new_frame, 616 visible lines, 4 blank lines.
    task automatic run_frame(input int chg_line, input logic [1:0] chg_mode, input int rst_line);
        exp_t f;
        bit   got, act, rst_now, nf;
        int   hs[7];
        for (int v = -1; v < 620; v++) begin
            if (v == chg_line) mode_in = chg_mode;
            hs[0] = 0; hs[1] = 819;
            hs[2] = $urandom_range(0, 819); hs[3] = $urandom_range(0, 819);
            hs[4] = 820; hs[5] = 900; hs[6] = 1300;
            for (int k = 0; k < 7; k++) begin
                act     = (v >= 0) && (v < HEIGHT * SC) && (k < 6);
                rst_now = (v == rst_line) && (k == 0);
                nf      = (v == -1) && (k == 6);
                drive(hs[k], (v < 0) ? 620 : v, act, nf, rst_now, f, got);
                if (rst_now) begin
                    n_cmp++;
                    if (rgb_out !== 24'h0 || active_out !== 1'b0 || addr_out[0] !== 15'd0) begin
                        n_bad++;
                        $display("FAIL midframe_reset: rgb=%h act=%b addr=%0d required 0/0/0",
                                 rgb_out, active_out, addr_out[0]);
                    end
                end else if (got && f.chk) begin
                    n_cmp++;
                    if (rgb_out !== f.rgb || active_out !== f.act) begin
                        n_bad++;
                        $display("FAIL frame_pixel (line %0d k %0d): rgb=%h act=%b required rgb=%h act=%b",
                                 v, k, rgb_out, active_out, f.rgb, f.act);
                    end
                end
                if (v == rst_line + 1 && k == 2) begin
                    n_cmp++;
                    if (addr_out[0] !== 15'(hs[2] / SC)) begin
                        n_bad++;
                        $display("FAIL row_base_after_reset: addr=%0d required %0d",
                                 addr_out[0], hs[2] / SC);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        exp_t f;
        bit   got;
        for (int r = 0; r < 2; r++) begin
            drive(0, 0, 1, 0, 1, f, got);
            n_cmp++;
            if (rgb_out !== 24'h0 || active_out !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: rgb=%h act=%b required 000000/0", rgb_out, active_out);
            end
            for (int ln = 0; ln < 9; ln++) begin
                n_cmp++;
                if (addr_out[ln] !== 15'd0) begin
                    n_bad++;
                    $display("FAIL reset_addr lane %0d: %0d required 0", ln, addr_out[ln]);
                end
            end
        end
    endtask

    task automatic test_addr();
        exp_t       f;
        bit         got;
        int         h;
        logic [14:0] want;
        want = 15'd0;
        drive(1300, 620, 0, 1, 0, f, got);
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 3; k++) begin
                h = (v == 5 && k == 0) ? 9 : $urandom_range(0, 819);
                drive(h, v, 1, 0, 0, f, got);
                want = 15'((v / SC) * WIDTH + h / SC);
                for (int ln = 0; ln < 9; ln++) begin
                    n_cmp++;
                    if (addr_out[ln] !== want) begin
                        n_bad++;
                        $display("FAIL addr (h %0d v %0d lane %0d): %0d required %0d",
                                 h, v, ln, addr_out[ln], want);
                    end
                end
            end
            drive(900, v, 1, 0, 0, f, got);
            n_cmp++;
            if (addr_out[0] !== want) begin
                n_bad++;
                $display("FAIL addr_hold (v %0d): %0d required %0d", v, addr_out[0], want);
            end
            drive(820, v, 1, 0, 0, f, got);
        end
    endtask

    task automatic test_colors();
        exp_t f;
        bit   got;
        int          tm[8] = '{1, 1, 2, 3, 3, 0, 0, 0};
        int          th[8] = '{0, 4, 12, 0, 8, 8, 900, 100};
        int          tv[8] = '{0, 0, 0, 0, 0, 0, 10, 10};
        bit          ta[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        logic [23:0] te[8] = '{24'hBE0000, 24'h0000BE, 24'hBE0000, 24'h00BE00,
                               24'h000000, 24'hFFFFFF, 24'h202020, 24'h000000};
        fill_mem(0);
        mem[0] = '0; mem[0][2] = 8'd127; mem[0][3] = 8'd127; mem[0][4] = 8'd127;
        mem[1] = '0; mem[1][6] = 8'd127; mem[1][7] = 8'd127; mem[1][8] = 8'd127;
        mem[2] = {9{8'hFF}};
        mem[3] = '0; mem[3][1] = 8'd127; mem[3][2] = 8'd127; mem[3][8] = 8'd127;
        for (int t = 0; t < 8; t++) begin
            mode_in = 2'(tm[t]);
            drive(1300, 620, 0, 1, 0, f, got);
            drive(th[t], tv[t], ta[t], 0, 0, f, got);
            for (int i = 0; i < 4; i++) drive(1300, 620, 0, 0, 0, f, got);
            n_cmp++;
            if (rgb_out !== te[t] || active_out !== ta[t]) begin
                n_bad++;
                $display("FAIL color case %0d: rgb=%h act=%b required rgb=%h act=%b",
                         t, rgb_out, active_out, te[t], ta[t]);
            end
        end
    endtask

    task automatic test_uniform();
        fill_mem(0);
        mode_in = 2'd0;
        run_frame(-5, 2'd0, -5);
    endtask

    task automatic test_mode_latch();
        fill_mem(1);
        mode_in = 2'd0;
        run_frame(100, 2'd2, -5);
        run_frame(-5, 2'd0, -5);
    endtask

    task automatic test_reset_midframe();
        fill_mem(1);
        mode_in = 2'd1;
        run_frame(-5, 2'd0, 50);
        run_frame(-5, 2'd0, -5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 2; n++) begin
            fill_mem(1);
            mode_in = 2'($urandom_range(0, 3));
            run_frame($urandom_range(0, 615), 2'($urandom_range(0, 3)), -5);
        end
    endtask

    initial begin
        rst_in       = 1'b1;
        hcount_in    = '0;
        vcount_in    = '0;
        active_in    = 1'b0;
        new_frame_in = 1'b0;
        mode_in      = 2'd0;
        fm_model     = 2'd0;
        sb_valid     = 1'b0;
        fill_mem(0);
        test_reset();
        test_addr();
        test_colors();
        test_uniform();
        test_mode_latch();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
